vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 137 +++++++++++++
 tb/tb_vga_timing_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: shadowed timing registers, live counters, registered sync/blank/RGB.
// Define VGA_TIMING_UNDERFLOW_EN to substitute UF_COLOR and flag underflow when the pixel source runs dry.
module vga_timing_gen #(
  parameter int              CW       = 4,
  parameter int              HW       = 12,
  parameter int              VW       = 11,
  parameter logic            HS_POL   = 1'b0,
  parameter logic            VS_POL   = 1'b0,
  parameter logic [3*CW-1:0] UF_COLOR = '0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            en_i,
  input  logic            pix_ce_i,
  input  logic [HW-1:0]   hsync_end_i,
  input  logic [HW-1:0]   hpulse_end_i,
  input  logic [HW-1:0]   hdata_begin_i,
  input  logic [HW-1:0]   hdata_end_i,
  input  logic [VW-1:0]   vsync_end_i,
  input  logic [VW-1:0]   vpulse_end_i,
  input  logic [VW-1:0]   vdata_begin_i,
  input  logic [VW-1:0]   vdata_end_i,
  input  logic [3*CW-1:0] data_i,
  input  logic            data_valid_i,
  input  logic            underflow_clr_i,
  output logic            data_req_o,
  output logic [CW-1:0]   red_o,
  output logic [CW-1:0]   green_o,
  output logic [CW-1:0]   blue_o,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic            blank_o,
  output logic            line_start_o,
  output logic            frame_start_o,
  output logic [HW-1:0]   hcount_o,
  output logic [VW-1:0]   vcount_o,
  output logic            underflow_o
);

  logic [HW-1:0]   hcount, hs_end, hp_end, hd_beg, hd_end;
  logic [VW-1:0]   vcount, vs_end, vp_end, vd_beg, vd_end;
  logic [3*CW-1:0] rgb, pix;
  logic            tick, h_wrap, v_wrap, active;

  assign tick   = en_i & pix_ce_i;
  // End values of 0 or 1 pin the counter at 0 instead of underflowing end-1.
  assign h_wrap = (hs_end <= HW'(1)) || (hcount >= hs_end - HW'(1));
  assign v_wrap = (vs_end <= VW'(1)) || (vcount >= vs_end - VW'(1));
  assign active = (hcount >= hd_beg) && (hcount < hd_end) &&
                  (vcount >= vd_beg) && (vcount < vd_end);

  assign data_req_o = active & tick;
  assign hcount_o   = hcount;
  assign vcount_o   = vcount;
  assign red_o      = rgb[CW-1:0];
  assign green_o    = rgb[2*CW-1:CW];
  assign blue_o     = rgb[3*CW-1:2*CW];

  // Timing only reloads while idle or at the frame boundary so a frame is never torn.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hs_end <= '0; hp_end <= '0; hd_beg <= '0; hd_end <= '0;
      vs_end <= '0; vp_end <= '0; vd_beg <= '0; vd_end <= '0;
    end else if (!en_i || (tick && h_wrap && v_wrap)) begin
      hs_end <= hsync_end_i;   hp_end <= hpulse_end_i;
      hd_beg <= hdata_begin_i; hd_end <= hdata_end_i;
      vs_end <= vsync_end_i;   vp_end <= vpulse_end_i;
      vd_beg <= vdata_begin_i; vd_end <= vdata_end_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hcount <= '0;
      vcount <= '0;
    end else if (!en_i) begin
      hcount <= '0;
      vcount <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        hcount <= '0;
        vcount <= v_wrap ? '0 : vcount + VW'(1);
      end else begin
        hcount <= hcount + HW'(1);
      end
    end
  end

  always_comb begin
    pix = '0;
    if (active) pix = data_i;
`ifdef VGA_TIMING_UNDERFLOW_EN
    if (active && !data_valid_i) pix = UF_COLOR;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hsync_o       <= ~HS_POL;
      vsync_o       <= ~VS_POL;
      blank_o       <= 1'b0;
      rgb           <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else if (!en_i) begin
      hsync_o       <= ~HS_POL;
      vsync_o       <= ~VS_POL;
      blank_o       <= 1'b0;
      rgb           <= '0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else if (tick) begin
      hsync_o       <= (hcount < hp_end) ? HS_POL : ~HS_POL;
      vsync_o       <= (vcount < vp_end) ? VS_POL : ~VS_POL;
      blank_o       <= active;
      rgb           <= pix;
      line_start_o  <= (hcount == '0);
      frame_start_o <= (hcount == '0) && (vcount == '0);
    end else begin
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end
  end

`ifdef VGA_TIMING_UNDERFLOW_EN
  // Set has priority so an underflow coinciding with a clear is not lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                           underflow_o <= 1'b0;
    else if (data_req_o && !data_valid_i)  underflow_o <= 1'b1;
    else if (underflow_clr_i)              underflow_o <= 1'b0;
  end
`else
  assign underflow_o = 1'b0;
  wire unused_uf = &{1'b0, data_valid_i, underflow_clr_i, UF_COLOR};
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a per-tick raster model pushes expected outputs, compared after each edge.
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en_i = 1'b0, pix_ce_i = 1'b0;
  logic [11:0] hsync_end_i = 12'd10, hpulse_end_i = 12'd2, hdata_begin_i = 12'd3, hdata_end_i = 12'd8;
  logic [10:0] vsync_end_i = 11'd6, vpulse_end_i = 11'd1, vdata_begin_i = 11'd2, vdata_end_i = 11'd5;
  logic [11:0] data_i = '0;
  logic        data_valid_i = 1'b1, underflow_clr_i = 1'b0;
  logic        data_req_o, hsync_o, vsync_o, blank_o, line_start_o, frame_start_o, underflow_o;
  logic [3:0]  red_o, green_o, blue_o;
  logic [11:0] hcount_o;
  logic [10:0] vcount_o;

  localparam logic [11:0] UFC = 12'hABC;

  vga_timing_gen #(.CW(4), .HW(12), .VW(11), .HS_POL(1'b0), .VS_POL(1'b0), .UF_COLOR(UFC)) dut (
    .clk(clk), .resetn(resetn), .en_i(en_i), .pix_ce_i(pix_ce_i),
    .hsync_end_i(hsync_end_i), .hpulse_end_i(hpulse_end_i),
    .hdata_begin_i(hdata_begin_i), .hdata_end_i(hdata_end_i),
    .vsync_end_i(vsync_end_i), .vpulse_end_i(vpulse_end_i),
    .vdata_begin_i(vdata_begin_i), .vdata_end_i(vdata_end_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .underflow_clr_i(underflow_clr_i),
    .data_req_o(data_req_o), .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .blank_o(blank_o),
    .line_start_o(line_start_o), .frame_start_o(frame_start_o),
    .hcount_o(hcount_o), .vcount_o(vcount_o), .underflow_o(underflow_o));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hs, vs, bl, ls, fs;
    logic [11:0] rgb;
    logic        uf;
    logic [11:0] hc;
    logic [10:0] vc;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   mh, mv, mhend, mvend;
  int   checks = 0, failures = 0;

  function automatic exp_t observed();
    exp_t o;
    o = '{hs: hsync_o, vs: vsync_o, bl: blank_o, ls: line_start_o, fs: frame_start_o,
          rgb: {blue_o, green_o, red_o}, uf: underflow_o, hc: hcount_o, vc: vcount_o};
    return o;
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; mhend = 0; mvend = 0;
    m = '{hs: 1'b1, vs: 1'b1, default: '0};
  endtask

  // One clk cycle: drive at negedge, predict, push, then pop and compare after the edge.
  task automatic cyc(input logic en, input logic ce, input logic dv, input logic clr);
    logic act, req;
    exp_t e, got;
    en_i = en; pix_ce_i = ce; data_valid_i = dv; underflow_clr_i = clr;
    data_i = 12'($urandom);
    #1;
    act = en && mh >= 3 && mh < 8 && mv >= 2 && mv < 5;
    req = act && ce;
    checks++;
    if (data_req_o !== req) begin
      failures++;
      $display("FAIL data_req h=%0d v=%0d got %b want %b", mh, mv, data_req_o, req);
    end
    if (!en) begin
      mh = 0; mv = 0; mhend = int'(hsync_end_i); mvend = int'(vsync_end_i);
      m.hs = 1; m.vs = 1; m.bl = 0; m.ls = 0; m.fs = 0; m.rgb = '0;
    end else if (ce) begin
      m.hs = !(mh < 2); m.vs = !(mv < 1); m.bl = act;
      m.ls = (mh == 0); m.fs = (mh == 0 && mv == 0);
      m.rgb = act ? data_i : 12'h000;
`ifdef VGA_TIMING_UNDERFLOW_EN
      if (act && !dv) m.rgb = UFC;
`endif
      if (mh + 1 >= mhend) begin
        mh = 0;
        if (mv + 1 >= mvend) begin
          mv = 0; mhend = int'(hsync_end_i); mvend = int'(vsync_end_i);
        end else mv++;
      end else mh++;
    end else begin
      m.ls = 0; m.fs = 0;
    end
`ifdef VGA_TIMING_UNDERFLOW_EN
    if (req && !dv) m.uf = 1;
    else if (clr)   m.uf = 0;
`endif
    m.hc = 12'(mh); m.vc = 11'(mv);
    q.push_back(m);
    @(posedge clk); #1;
    e = q.pop_front();
    got = observed();
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL sb_out got %h want %h", got, e);
    end
    @(negedge clk);
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(hcount_o == 12'(h) && vcount_o == 11'(v)) && n < 200) begin
      cyc(1, 1, 1, 0); n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL run_to_timeout got h=%0d v=%0d want h=%0d v=%0d", hcount_o, vcount_o, h, v);
    end
  endtask

  task automatic check_idle(input string name);
    exp_t want;
    want = '{hs: 1'b1, vs: 1'b1, default: '0};
    want.uf = underflow_o;
    checks++;
    if (observed() !== want) begin
      failures++;
      $display("FAIL %s got %h want %h", name, observed(), want);
    end
  endtask

  task automatic test_reset();
    resetn = 0;
    @(negedge clk); @(negedge clk);
    model_reset();
    checks++;
    if (underflow_o !== 1'b0) begin
      failures++; $display("FAIL reset_uf got %b want 0", underflow_o);
    end
    check_idle("reset_state");
    resetn = 1;
    cyc(0, 1, 1, 0); cyc(0, 0, 1, 0);
  endtask

  task automatic test_frame();
    int hs_lo = 0, vs_lo = 0, bl_hi = 0, fs_n = 0, ls_n = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1, 1, 1, 0);
      hs_lo += int'(!hsync_o); vs_lo += int'(!vsync_o); bl_hi += int'(blank_o);
      fs_n += int'(frame_start_o); ls_n += int'(line_start_o);
    end
    checks++;
    if ({hs_lo, vs_lo, bl_hi, fs_n, ls_n} !== {32'd12, 32'd10, 32'd15, 32'd1, 32'd6}) begin
      failures++;
      $display("FAIL frame_counts got hs=%0d vs=%0d bl=%0d fs=%0d ls=%0d want 12 10 15 1 6",
               hs_lo, vs_lo, bl_hi, fs_n, ls_n);
    end
  endtask

  task automatic test_pix_ce();
    int bl_hi = 0, fs_n = 0, wide = 0;
    logic prev_ls = 0, prev_fs = 0;
    for (int i = 0; i < 120; i++) begin
      cyc(1, (i % 2) == 0, 1, 0);
      bl_hi += int'(blank_o); fs_n += int'(frame_start_o);
      if ((prev_ls && line_start_o) || (prev_fs && frame_start_o)) wide++;
      prev_ls = line_start_o; prev_fs = frame_start_o;
    end
    checks++;
    if ({bl_hi, fs_n, wide} !== {32'd30, 32'd1, 32'd0}) begin
      failures++;
      $display("FAIL pix_ce got bl=%0d fs=%0d wide=%0d want 30 1 0", bl_hi, fs_n, wide);
    end
  endtask

  task automatic test_mid_change();
    int mx = 0;
    for (int i = 0; i < 25; i++) cyc(1, 1, 1, 0);
    hsync_end_i = 12'd12;
    for (int i = 0; i < 35; i++) begin
      cyc(1, 1, 1, 0);
      if (int'(hcount_o) > mx) mx = int'(hcount_o);
    end
    checks++;
    if (mx != 9) begin failures++; $display("FAIL mid_change_old got %0d want 9", mx); end
    mx = 0;
    for (int i = 0; i < 72; i++) begin
      cyc(1, 1, 1, 0);
      if (int'(hcount_o) > mx) mx = int'(hcount_o);
    end
    checks++;
    if (mx != 11) begin failures++; $display("FAIL mid_change_new got %0d want 11", mx); end
    hsync_end_i = 12'd10;
  endtask

  task automatic test_en_drop();
    run_to(5, 3);
    cyc(0, 1, 1, 0);
    check_idle("en_drop_idle");
    cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 0);
    checks++;
    if ({frame_start_o, hcount_o, vcount_o} !== {1'b1, 12'd1, 11'd0}) begin
      failures++;
      $display("FAIL en_restart got fs=%b h=%0d v=%0d want fs=1 h=1 v=0", frame_start_o, hcount_o, vcount_o);
    end
    for (int i = 0; i < 59; i++) cyc(1, 1, 1, 0);
  endtask

  task automatic test_reset_mid();
    run_to(5, 3);
    resetn = 0; en_i = 0;
    #1;
    model_reset();
    check_idle("reset_async");
    checks++;
    if (underflow_o !== 1'b0) begin
      failures++; $display("FAIL reset_mid_uf got %b want 0", underflow_o);
    end
    @(negedge clk);
    resetn = 1;
    cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 0);
    checks++;
    if ({frame_start_o, hcount_o, vcount_o} !== {1'b1, 12'd1, 11'd0}) begin
      failures++;
      $display("FAIL reset_restart got fs=%b h=%0d v=%0d want fs=1 h=1 v=0", frame_start_o, hcount_o, vcount_o);
    end
  endtask

`ifdef VGA_TIMING_UNDERFLOW_EN
  task automatic test_underflow();
    run_to(4, 2);
    cyc(1, 1, 0, 0);
    checks++;
    if ({blue_o, green_o, red_o, underflow_o} !== {UFC, 1'b1}) begin
      failures++;
      $display("FAIL uf_set got rgb=%h uf=%b want %h 1", {blue_o, green_o, red_o}, underflow_o, UFC);
    end
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0);
    run_to(5, 3);
    cyc(1, 1, 0, 1);
    checks++;
    if (underflow_o !== 1'b1) begin failures++; $display("FAIL uf_set_wins got %b want 1", underflow_o); end
    cyc(1, 1, 1, 1);
    checks++;
    if (underflow_o !== 1'b0) begin failures++; $display("FAIL uf_clear got %b want 0", underflow_o); end
  endtask
`else
  task automatic test_underflow();
    int uf_seen = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1, 1, 1'($urandom), 1'($urandom));
      uf_seen += int'(underflow_o);
    end
    checks++;
    if (uf_seen != 0) begin failures++; $display("FAIL uf_disabled got %0d want 0", uf_seen); end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_pix_ce();
    test_mid_change();
    test_en_drop();
    test_reset_mid();
    test_underflow();
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL sb_leftover got %0d want 0", q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
